// File: rtl/dino_game_if.sv
// dino_game_if: raw jump button in, renderer-facing game outputs
interface dino_game_if;
  logic        btn1;
  logic        frame_tick;
  logic [1:0]  game_state;
  logic        jumping;
  logic [5:0]  dino_y;
  logic [6:0]  obst_x;
  logic [15:0] score;
  modport master (input btn1, output frame_tick, game_state, jumping, dino_y, obst_x, score);
  modport slave (output btn1, input frame_tick, game_state, jumping, dino_y, obst_x, score);
endinterface

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: debounced jump input, frame ticks, game/jump FSMs, obstacle, collision and score
module dino_game_ctrl #(
  parameter logic [31:0] TICK_DIV       = 32'd450_000,
  parameter logic [31:0] DEBOUNCE_CYC   = 32'd54_000,
  parameter logic [5:0]  RISE_FRAMES    = 6'd16,
  parameter logic [5:0]  HANG_FRAMES    = 6'd6,
  parameter logic [6:0]  OBST_SPEED     = 7'd2,
  parameter logic [6:0]  DINO_X         = 7'd8,
  parameter logic [6:0]  DINO_W         = 7'd8,
  parameter logic [5:0]  OBST_H         = 6'd10,
  parameter logic [7:0]  LOCKOUT_FRAMES = 8'd60
) (
  input logic        clk,
  input logic        rst,
  dino_game_if.master io
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} game_e;
  typedef enum logic [1:0] {GROUND, RISE, HANG, FALL} phase_e;
  logic [1:0]  sync_q, sync_d;
  logic        db_q, db_d, press_q, press_d, tick_q, tick_d, req_q, req_d;
  logic [31:0] dcnt_q, dcnt_d, pcnt_q, pcnt_d;
  game_e       state_q, state_d;
  phase_e      phase_q, phase_d, jp_phase;
  logic [5:0]  hang_q, hang_d, jp_hang, y_q, y_d, jp_y;
  logic [6:0]  x_q, x_d, nx;
  logic [15:0] score_q, score_d, nscore;
  logic [7:0]  lock_q, lock_d;
  logic        differ, flip, wrap_x, req, hit;
  // synchronize the raw button, then accept a level only after it has been stable long enough
  always_comb begin
    sync_d = {sync_q[0], io.btn1};
    differ = sync_q[1] != db_q;
    flip   = differ && dcnt_q == DEBOUNCE_CYC - 32'd1;
    db_d   = flip ? ~db_q : db_q;
    dcnt_d = (differ && !flip) ? dcnt_q + 32'd1 : '0;
    press_d = flip && db_q;
    pcnt_d = (pcnt_q == TICK_DIV - 32'd1) ? '0 : pcnt_q + 32'd1;
    tick_d = pcnt_q == TICK_DIV - 32'd1;
  end
  // one frame of the jump arc, applied only when the game is running and a tick arrives
  always_comb begin
    req      = req_q || (press_q && phase_q == GROUND);
    jp_phase = phase_q;
    jp_y     = y_q;
    jp_hang  = hang_q;
    case (phase_q)
      GROUND: begin
        jp_phase = req ? RISE : GROUND;
        jp_y     = req ? 6'd1 : y_q;
      end
      RISE: begin
        jp_y     = y_q + 6'd1;
        jp_phase = (jp_y == RISE_FRAMES) ? HANG : RISE;
        jp_hang  = '0;
      end
      HANG: begin
        jp_hang  = hang_q + 6'd1;
        jp_phase = (jp_hang == HANG_FRAMES) ? FALL : HANG;
      end
      FALL: begin
        jp_y     = y_q - 6'd1;
        jp_phase = (jp_y == 6'd0) ? GROUND : FALL;
      end
    endcase
    wrap_x = x_q < OBST_SPEED;
    nx     = wrap_x ? 7'd127 : x_q - OBST_SPEED;
    nscore = (wrap_x && score_q != 16'hFFFF) ? score_q + 16'd1 : score_q;
    hit    = nx >= DINO_X && nx <= DINO_X + DINO_W - 7'd1 && jp_y < OBST_H;
  end
  // game state machine: presses change state immediately, everything else moves on frame ticks
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hang_d  = hang_q;
    y_d     = y_q;
    x_d     = x_q;
    score_d = score_q;
    lock_d  = lock_q;
    req_d   = req_q;
    case (state_q)
      IDLE: if (press_q) begin
        state_d = RUN;
        phase_d = GROUND;
        hang_d  = '0;
        y_d     = '0;
        x_d     = 7'd127;
        score_d = '0;
        req_d   = 1'b0;
      end
      RUN: begin
        req_d = tick_q ? 1'b0 : req;
        if (tick_q) begin
          phase_d = jp_phase;
          hang_d  = jp_hang;
          y_d     = jp_y;
          x_d     = nx;
          score_d = nscore;
          state_d = hit ? OVER : RUN;
          lock_d  = hit ? 8'd0 : lock_q;
        end
      end
      OVER: begin
        lock_d  = (tick_q && lock_q < LOCKOUT_FRAMES) ? lock_q + 8'd1 : lock_q;
        state_d = (press_q && lock_q >= LOCKOUT_FRAMES) ? IDLE : OVER;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      db_q    <= 1'b1;
      dcnt_q  <= '0;
      press_q <= 1'b0;
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
      req_q   <= 1'b0;
      state_q <= IDLE;
      phase_q <= GROUND;
      hang_q  <= '0;
      y_q     <= '0;
      x_q     <= 7'd127;
      score_q <= '0;
      lock_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      db_q    <= db_d;
      dcnt_q  <= dcnt_d;
      press_q <= press_d;
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
      req_q   <= req_d;
      state_q <= state_d;
      phase_q <= phase_d;
      hang_q  <= hang_d;
      y_q     <= y_d;
      x_q     <= x_d;
      score_q <= score_d;
      lock_q  <= lock_d;
    end
  end
  assign io.frame_tick = tick_q;
  assign io.game_state = state_q;
  assign io.jumping    = phase_q != GROUND;
  assign io.dino_y     = y_q;
  assign io.obst_x     = x_q;
  assign io.score      = score_q;
endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb_dino_game_ctrl: scenario tasks with queued expectations for the dino game sequencer
module tb_dino_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  int exp_q[$];
  int expj_q[$];
  int exps_q[$];
  always #5 clk = ~clk;
  dino_game_if io();
  dino_game_ctrl #(
    .TICK_DIV(32'd4), .DEBOUNCE_CYC(32'd3), .RISE_FRAMES(6'd4), .HANG_FRAMES(6'd2),
    .OBST_SPEED(7'd2), .DINO_X(7'd8), .DINO_W(7'd8), .OBST_H(6'd3), .LOCKOUT_FRAMES(8'd3)
  ) dut (.clk(clk), .rst(rst), .io(io));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tick();
    int n = 0;
    while (!io.frame_tick && n < 12) begin
      step();
      n++;
    end
    if (!io.frame_tick) begin
      total++;
      $display("FAIL tick_timeout: frame_tick=%0b required 1", io.frame_tick);
    end
    step();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    io.btn1 = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic press_btn();
    io.btn1 = 1'b0;
    repeat (7) step();
    io.btn1 = 1'b1;
    repeat (7) step();
  endtask
  task automatic enter_run();
    int n = 0;
    io.btn1 = 1'b0;
    while (io.game_state !== 2'd1 && n < 12) begin
      step();
      n++;
    end
    total++;
    if (io.game_state !== 2'd1) $display("FAIL enter_run: game_state=%0d required 1", io.game_state);
    else passed++;
  endtask
  task automatic test_reset();
    do_reset();
    total += 6;
    if (io.game_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", io.game_state); else passed++;
    if (io.jumping !== 1'b0) $display("FAIL rst_jumping: got %0b want 0", io.jumping); else passed++;
    if (io.dino_y !== 6'd0) $display("FAIL rst_dino_y: got %0d want 0", io.dino_y); else passed++;
    if (io.obst_x !== 7'd127) $display("FAIL rst_obst_x: got %0d want 127", io.obst_x); else passed++;
    if (io.score !== 16'd0) $display("FAIL rst_score: got %0d want 0", io.score); else passed++;
    if (io.frame_tick !== 1'b0) $display("FAIL rst_tick: got %0b want 0", io.frame_tick); else passed++;
  endtask
  task automatic test_press_latency();
    do_reset();
    io.btn1 = 1'b0;
    repeat (5) step();
    total++;
    if (io.game_state !== 2'd0) $display("FAIL latency_early: state=%0d want 0", io.game_state); else passed++;
    step();
    total += 3;
    if (io.game_state !== 2'd1) $display("FAIL latency_run: state=%0d want 1", io.game_state); else passed++;
    if (io.obst_x !== 7'd127) $display("FAIL start_obst_x: got %0d want 127", io.obst_x); else passed++;
    if (io.score !== 16'd0) $display("FAIL start_score: got %0d want 0", io.score); else passed++;
    repeat (20) step();
    total += 2;
    if (io.game_state !== 2'd1) $display("FAIL held_state: got %0d want 1", io.game_state); else passed++;
    if (io.jumping !== 1'b0) $display("FAIL start_no_jump: jumping=%0b want 0", io.jumping); else passed++;
    io.btn1 = 1'b1;
  endtask
  task automatic test_bounce();
    do_reset();
    io.btn1 = 1'b0;
    repeat (2) step();
    io.btn1 = 1'b1;
    repeat (10) step();
    total++;
    if (io.game_state !== 2'd0) $display("FAIL bounce_ignored: state=%0d want 0", io.game_state); else passed++;
    io.btn1 = 1'b0;
    repeat (3) step();
    io.btn1 = 1'b1;
    repeat (10) step();
    total++;
    if (io.game_state !== 2'd1) $display("FAIL clean_press: state=%0d want 1", io.game_state); else passed++;
  endtask
  task automatic test_jump();
    int n = 0;
    int e, ej;
    do_reset();
    enter_run();
    io.btn1 = 1'b1;
    repeat (8) step();
    exp_q = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0, 0, 0, 0};
    expj_q = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    io.btn1 = 1'b0;
    do begin
      wait_tick();
      n++;
    end while (io.dino_y == 6'd0 && n < 6);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) wait_tick();
      e = exp_q.pop_front();
      ej = expj_q.pop_front();
      total += 2;
      if (io.dino_y !== 6'(e)) $display("FAIL jump_y[%0d]: got %0d want %0d", i, io.dino_y, e); else passed++;
      if (io.jumping !== 1'(ej)) $display("FAIL jump_flag[%0d]: got %0b want %0d", i, io.jumping, ej); else passed++;
      if (i == 0) io.btn1 = 1'b1;
      if (i == 2) fork press_btn(); join_none
    end
  endtask
  task automatic test_collision();
    int ex, es;
    do_reset();
    enter_run();
    io.btn1 = 1'b1;
    for (int u = 1; u <= 60; u++) begin
      exp_q.push_back(u <= 56 ? 127 - 2 * u : 15);
      exps_q.push_back(u < 56 ? 1 : 2);
    end
    for (int u = 1; u <= 60; u++) begin
      wait_tick();
      ex = exp_q.pop_front();
      es = exps_q.pop_front();
      total += 3;
      if (io.obst_x !== 7'(ex)) $display("FAIL coll_x[%0d]: got %0d want %0d", u, io.obst_x, ex); else passed++;
      if (io.game_state !== 2'(es)) $display("FAIL coll_state[%0d]: got %0d want %0d", u, io.game_state, es); else passed++;
      if (io.dino_y !== 6'd0) $display("FAIL coll_y[%0d]: got %0d want 0", u, io.dino_y); else passed++;
    end
  endtask
  task automatic test_clear_obstacle();
    int ex, es, ec;
    do_reset();
    enter_run();
    io.btn1 = 1'b1;
    for (int u = 1; u <= 120; u++) begin
      exp_q.push_back(u <= 63 ? 127 - 2 * u : 127 - 2 * (u - 64));
      exps_q.push_back(u < 120 ? 1 : 2);
      expj_q.push_back(u >= 64 ? 1 : 0);
    end
    for (int u = 1; u <= 120; u++) begin
      wait_tick();
      ex = exp_q.pop_front();
      es = exps_q.pop_front();
      ec = expj_q.pop_front();
      total += 3;
      if (io.obst_x !== 7'(ex)) $display("FAIL clear_x[%0d]: got %0d want %0d", u, io.obst_x, ex); else passed++;
      if (io.game_state !== 2'(es)) $display("FAIL clear_state[%0d]: got %0d want %0d", u, io.game_state, es); else passed++;
      if (io.score !== 16'(ec)) $display("FAIL clear_score[%0d]: got %0d want %0d", u, io.score, ec); else passed++;
      if (u == 52) io.btn1 = 1'b0;
      if (u == 58) io.btn1 = 1'b1;
    end
  endtask
  task automatic test_over();
    wait_tick();
    press_btn();
    total += 4;
    if (io.game_state !== 2'd2) $display("FAIL lockout_ignore: state=%0d want 2", io.game_state); else passed++;
    if (io.obst_x !== 7'd15) $display("FAIL over_frozen_x: got %0d want 15", io.obst_x); else passed++;
    if (io.score !== 16'd1) $display("FAIL over_score: got %0d want 1", io.score); else passed++;
    if (io.dino_y !== 6'd0) $display("FAIL over_y: got %0d want 0", io.dino_y); else passed++;
    press_btn();
    total += 2;
    if (io.game_state !== 2'd0) $display("FAIL over_to_idle: state=%0d want 0", io.game_state); else passed++;
    if (io.score !== 16'd1) $display("FAIL idle_score_kept: got %0d want 1", io.score); else passed++;
    enter_run();
    total += 2;
    if (io.obst_x !== 7'd127) $display("FAIL restart_x: got %0d want 127", io.obst_x); else passed++;
    if (io.score !== 16'd0) $display("FAIL restart_score: got %0d want 0", io.score); else passed++;
    io.btn1 = 1'b1;
  endtask
  task automatic test_reset_mid_jump();
    int n = 0;
    do_reset();
    enter_run();
    io.btn1 = 1'b1;
    repeat (8) step();
    io.btn1 = 1'b0;
    while (!io.jumping && n < 20) begin
      step();
      n++;
    end
    total++;
    if (io.jumping !== 1'b1) $display("FAIL mid_jump_start: jumping=%0b want 1", io.jumping); else passed++;
    repeat (3) step();
    rst = 1'b1;
    io.btn1 = 1'b1;
    step();
    total += 6;
    if (io.game_state !== 2'd0) $display("FAIL mid_rst_state: got %0d want 0", io.game_state); else passed++;
    if (io.jumping !== 1'b0) $display("FAIL mid_rst_jumping: got %0b want 0", io.jumping); else passed++;
    if (io.dino_y !== 6'd0) $display("FAIL mid_rst_y: got %0d want 0", io.dino_y); else passed++;
    if (io.obst_x !== 7'd127) $display("FAIL mid_rst_x: got %0d want 127", io.obst_x); else passed++;
    if (io.score !== 16'd0) $display("FAIL mid_rst_score: got %0d want 0", io.score); else passed++;
    if (io.frame_tick !== 1'b0) $display("FAIL mid_rst_tick: got %0b want 0", io.frame_tick); else passed++;
    rst = 1'b0;
    repeat (10) step();
    total++;
    if (io.game_state !== 2'd0) $display("FAIL post_rst_idle: state=%0d want 0", io.game_state); else passed++;
  endtask
  initial begin
    io.btn1 = 1'b1;
    test_reset();
    test_press_latency();
    test_bounce();
    test_jump();
    test_collision();
    test_clear_obstacle();
    test_over();
    test_reset_mid_jump();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end
endmodule
